rng_fifo: RTL and testbench

- Parametrised successor to the single-word LFSR RNG peripheral.
- A Galois LFSR with a configurable polynomial produces one word every STEPS clocks into a prefetch FIFO, so CPU reads normally complete without stalling.
- Adds zero-lock protection, flush-on-reseed and a sticky repetition-count health test.
- Sits on the SoC memory-mapped bus next to the UART/SPI peripherals.

---
 rtl/rng_fifo.sv | 186 ++++++++++++++++++
 tb/tb_rng_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rng_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rng_fifo
// Purpose  : Galois-LFSR random number generator with a prefetch FIFO,
//            zero-seed protection, flush-on-reseed and a sticky
//            repetition-count health test. The generator shifts once per clock
//            and pushes one word every STEPS shifts, so bus reads normally
//            complete without wait states.
// Ports    : clk         - clock
//            resetn      - asynchronous active-low reset
//            enable      - generator and read enable
//            seed_we     - one-cycle seed load strobe (highest priority)
//            seed_di     - seed value (zero selects SEED_RESET)
//            dat_re      - read request
//            dat_do      - FIFO head word (0 when empty)
//            dat_wait    - read not accepted this cycle
//            fifo_level  - number of words held
//            health_fail - sticky repetition-test failure
// Revision : 1.0 - initial release
// ============================================================================
module rng_fifo #(
  parameter int          NUM_BITS   = 32,
  parameter logic [31:0] POLY       = 32'h80200003,
  parameter logic [31:0] SEED_RESET = 32'd1,
  parameter int          STEPS      = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter int          REP_LIMIT  = 3
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          seed_we,
  input  logic [NUM_BITS-1:0]           seed_di,
  input  logic                          dat_re,
  output logic [NUM_BITS-1:0]           dat_do,
  output logic                          dat_wait,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int RW = $clog2(REP_LIMIT);

  localparam logic [NUM_BITS-1:0] C_POLY     = POLY[NUM_BITS-1:0];
  localparam logic [NUM_BITS-1:0] C_SEED     = SEED_RESET[NUM_BITS-1:0];
  localparam logic [CW-1:0]       C_CNT_LAST = CW'(STEPS - 1);
  localparam logic [RW-1:0]       C_REP_LAST = RW'(REP_LIMIT - 1);
  localparam logic [LW-1:0]       C_FULL     = LW'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NUM_BITS-1:0] state_q,    state_d;
  logic [CW-1:0]       cnt_q,      cnt_d;
  logic [NUM_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [NUM_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q,   rd_ptr_d;
  logic [LW-1:0]       level_q,    level_d;
  logic [RW-1:0]       rep_q,      rep_d;
  logic [NUM_BITS-1:0] prev_q,     prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic                hfail_q,    hfail_d;

  logic                w_full;
  logic                w_empty;
  logic                w_gen_go;
  logic                w_push;
  logic                w_pop;
  logic [NUM_BITS-1:0] w_step;
  logic [RW-1:0]       w_rep_nxt;

  // --------------------------------------------------------------------------
  // Datapath and control
  // --------------------------------------------------------------------------
  always_comb begin
    w_full  = (level_q == C_FULL);
    w_empty = (level_q == '0);

    // One Galois shift. An all-zero state maps to itself; it is left alone and
    // the repetition test flags the resulting constant stream.
    w_step = {1'b0, state_q[NUM_BITS-1:1]} ^ (state_q[0] ? C_POLY : '0);

    // Fullness is judged on the level at cycle start, so a pop in the same
    // cycle does not unblock the generator until the next cycle.
    w_gen_go = enable & ~w_full & ~seed_we;
    w_push   = w_gen_go & (cnt_q == C_CNT_LAST);

    dat_wait = ~enable | w_empty | seed_we | hfail_q;
    w_pop    = dat_re & ~dat_wait;

    // Saturate the run counter at its trip value; health_fail is sticky anyway.
    if (prev_vld_q && (w_step == prev_q)) begin
      w_rep_nxt = (rep_q == C_REP_LAST) ? rep_q : rep_q + 1'b1;
    end else begin
      w_rep_nxt = '0;
    end

    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rep_d      = rep_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    hfail_d    = hfail_q;

    if (seed_we) begin
      state_d    = (seed_di == '0) ? C_SEED : seed_di;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      rep_d      = '0;
      prev_vld_d = 1'b0;
      hfail_d    = 1'b0;
    end else begin
      if (w_gen_go) begin
        state_d = w_step;
        cnt_d   = w_push ? '0 : cnt_q + 1'b1;
      end

      if (w_push) begin
        mem_d[wr_ptr_q] = w_step;
        wr_ptr_d        = wr_ptr_q + 1'b1;
        rep_d           = w_rep_nxt;
        prev_d          = w_step;
        prev_vld_d      = 1'b1;
        if (w_rep_nxt == C_REP_LAST) begin
          hfail_d = 1'b1;
        end
      end

      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= C_SEED;
      cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rep_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      hfail_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rep_q      <= rep_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      hfail_q    <= hfail_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dat_do      = w_empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_level  = level_q;
  assign health_fail = hfail_q;

endmodule
`default_nettype wire

// File: tb/tb_rng_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_fifo
// Purpose  : Directed self-checking bench for rng_fifo. Three instances:
//            a - 8-bit, POLY 8'hB8, STEPS 1 (fill / streaming reads)
//            b - default 32-bit, STEPS 32 (zero seed, reseed, enable freeze,
//                asynchronous reset)
//            c - 8-bit, POLY 0, STEPS 8 (repetition health test)
// Revision : 1.0 - initial release
// ============================================================================
module tb_rng_fifo;

  logic clk;
  logic resetn;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- instance a ----------------
  logic       a_en, a_sw, a_re, a_wait, a_hf;
  logic [7:0] a_sd, a_do;
  logic [2:0] a_lvl;

  // ---------------- instance b ----------------
  logic        b_en, b_sw, b_re, b_wait, b_hf;
  logic [31:0] b_sd, b_do;
  logic [2:0]  b_lvl;

  // ---------------- instance c ----------------
  logic       c_en, c_sw, c_re, c_wait, c_hf;
  logic [7:0] c_sd, c_do;
  logic [2:0] c_lvl;

  rng_fifo #(
    .NUM_BITS(8), .POLY(32'h000000B8), .SEED_RESET(32'd1),
    .STEPS(1), .FIFO_DEPTH(4), .REP_LIMIT(3)
  ) u_a (
    .clk(clk), .resetn(resetn), .enable(a_en), .seed_we(a_sw), .seed_di(a_sd),
    .dat_re(a_re), .dat_do(a_do), .dat_wait(a_wait), .fifo_level(a_lvl),
    .health_fail(a_hf)
  );

  rng_fifo u_b (
    .clk(clk), .resetn(resetn), .enable(b_en), .seed_we(b_sw), .seed_di(b_sd),
    .dat_re(b_re), .dat_do(b_do), .dat_wait(b_wait), .fifo_level(b_lvl),
    .health_fail(b_hf)
  );

  rng_fifo #(
    .NUM_BITS(8), .POLY(32'h00000000), .SEED_RESET(32'd1),
    .STEPS(8), .FIFO_DEPTH(4), .REP_LIMIT(3)
  ) u_c (
    .clk(clk), .resetn(resetn), .enable(c_en), .seed_we(c_sw), .seed_di(c_sd),
    .dat_re(c_re), .dat_do(c_do), .dat_wait(c_wait), .fifo_level(c_lvl),
    .health_fail(c_hf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 2 time units after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference Galois LFSR for the default 32-bit polynomial.
  function automatic logic [31:0] gal32(input logic [31:0] s, input int n);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < n; i++) begin
      v = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    end
    return v;
  endfunction

  logic [7:0]  exp_a [6];
  logic [31:0] w_b1, w_b2, w_b3;

  initial begin
    exp_a = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1};
    w_b1  = gal32(32'h00000001, 32);
    w_b2  = gal32(32'h5A5A5A5A, 32);
    w_b3  = gal32(32'h5A5A5A5A, 64);

    {a_en, a_sw, a_re} = '0; a_sd = '0;
    {b_en, b_sw, b_re} = '0; b_sd = '0;
    {c_en, c_sw, c_re} = '0; c_sd = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("rst_a_level", 32'(a_lvl), 32'd0);
    check("rst_a_wait",  32'(a_wait), 32'd1);
    check("rst_a_do",    32'(a_do), 32'd0);
    check("rst_c_hfail", 32'(c_hf), 32'd0);
    tick(2);
    resetn = 1'b1;

    // ---------------- fill, stall, stream (instance a) ----------------
    a_en = 1'b1;
    tick(3);
    check("a_level_3", 32'(a_lvl), 32'd3);
    tick(1);
    check("a_level_full", 32'(a_lvl), 32'd4);
    check("a_head", 32'(a_do), 32'hB8);
    check("a_wait_full", 32'(a_wait), 32'd0);
    tick(2);
    check("a_stall_level", 32'(a_lvl), 32'd4);
    check("a_stall_head", 32'(a_do), 32'hB8);

    a_re = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("a_read%0d", i), 32'(a_do), 32'(exp_a[i]));
      tick(1);
      check($sformatf("a_lvl_rd%0d", i), 32'(a_lvl), 32'd3);
    end
    a_re = 1'b0;
    tick(1);
    check("a_refill_level", 32'(a_lvl), 32'd4);
    check("a_refill_head", 32'(a_do), 32'hC8);
    a_en = 1'b0;

    // ---------------- repetition health test (instance c) ----------------
    c_en = 1'b1;
    tick(8);
    check("c_lvl1", 32'(c_lvl), 32'd1);
    check("c_word0", 32'(c_do), 32'h00);
    check("c_hf_1", 32'(c_hf), 32'd0);
    tick(8);
    check("c_lvl2", 32'(c_lvl), 32'd2);
    tick(7);
    check("c_hf_2", 32'(c_hf), 32'd0);
    tick(1);
    check("c_hf_3", 32'(c_hf), 32'd1);
    check("c_lvl3", 32'(c_lvl), 32'd3);
    check("c_wait_hf", 32'(c_wait), 32'd1);
    c_re = 1'b1;
    tick(9);
    check("c_lvl_hold", 32'(c_lvl), 32'd4);
    check("c_hf_sticky", 32'(c_hf), 32'd1);
    check("c_wait_sticky", 32'(c_wait), 32'd1);
    c_en = 1'b0; c_re = 1'b0;
    c_sw = 1'b1; c_sd = 8'h01;
    tick(1);
    c_sw = 1'b0;
    check("c_hf_clear", 32'(c_hf), 32'd0);
    check("c_flush", 32'(c_lvl), 32'd0);

    // ---------------- zero seed, first-word latency (instance b) ----------------
    b_en = 1'b1; b_sw = 1'b1; b_sd = 32'h0; b_re = 1'b1;
    tick(1);
    b_sw = 1'b0;
    #1;
    check("b_wait_empty", 32'(b_wait), 32'd1);
    tick(31);
    check("b_lvl_31", 32'(b_lvl), 32'd0);
    check("b_wait_31", 32'(b_wait), 32'd1);
    b_re = 1'b0;
    tick(1);
    check("b_lvl_32", 32'(b_lvl), 32'd1);
    check("b_word_seed0", b_do, w_b1);

    // ---------------- reseed mid-fill with concurrent read ----------------
    tick(10);
    b_sw = 1'b1; b_sd = 32'h5A5A5A5A; b_re = 1'b1;
    #1;
    check("b_wait_seed", 32'(b_wait), 32'd1);
    tick(1);
    b_sw = 1'b0; b_re = 1'b0;
    check("b_flush", 32'(b_lvl), 32'd0);
    tick(31);
    check("b_lvl_rs31", 32'(b_lvl), 32'd0);
    tick(1);
    check("b_lvl_rs32", 32'(b_lvl), 32'd1);
    check("b_word_5a", b_do, w_b2);

    // ---------------- enable freeze mid-word ----------------
    tick(10);
    b_en = 1'b0;
    tick(5);
    check("b_frz_lvl", 32'(b_lvl), 32'd1);
    b_en = 1'b1;
    tick(21);
    check("b_resume_31", 32'(b_lvl), 32'd1);
    tick(1);
    check("b_resume_32", 32'(b_lvl), 32'd2);
    b_re = 1'b1;
    #1;
    check("b_rd_head", b_do, w_b2);
    tick(1);
    b_re = 1'b0;
    check("b_lvl_pop", 32'(b_lvl), 32'd1);
    check("b_word2", b_do, w_b3);

    // ---------------- asynchronous reset between edges ----------------
    tick(3);
    #1 resetn = 1'b0;
    #1;
    check("arst_b_lvl", 32'(b_lvl), 32'd0);
    check("arst_b_wait", 32'(b_wait), 32'd1);
    check("arst_b_hf", 32'(b_hf), 32'd0);
    check("arst_b_do", b_do, 32'd0);
    check("arst_a_lvl", 32'(a_lvl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
